// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clkdiv_multi clock-enable generator.
package clkdiv_pkg;

    localparam int DEFAULT_DIV_W = 16;

    typedef logic [DEFAULT_DIV_W-1:0] div_t;

    // A divisor of zero parks the channel instead of dividing.
    localparam int DIV_HALT = 0;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/pending divisor pair, tick and clk_out flops.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               DIV_W       = DEFAULT_DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(10000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_advance,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wdata,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic             o_pending
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_pending;
    logic             r_pend_flag;
    logic             r_tick;
    logic             r_clk_out;

    logic w_halted;
    logic w_terminal;
    logic w_commit;

    // A halted channel commits a waiting divisor at once, otherwise only at a period boundary.
    assign w_halted   = (r_active == DIV_W'(DIV_HALT));
    assign w_terminal = !w_halted && i_advance && (r_count == r_active - ONE);
    assign w_commit   = r_pend_flag && (w_halted || w_terminal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_active    <= DEFAULT_DIV;
            r_pending   <= DEFAULT_DIV;
            r_pend_flag <= 1'b0;
            r_tick      <= 1'b0;
            r_clk_out   <= 1'b0;
        end else begin
            if (w_halted) begin
                r_count <= '0;
                r_tick  <= 1'b0;
            end else if (w_terminal) begin
                r_count   <= '0;
                r_tick    <= 1'b1;
                r_clk_out <= ~r_clk_out;
            end else if (i_advance) begin
                r_count <= r_count + ONE;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= 1'b0;
            end

            if (w_commit) begin
                r_active <= r_pending;
            end

            // A write on a commit edge lands behind the value being committed.
            if (i_wr) begin
                r_pending   <= i_wdata;
                r_pend_flag <= 1'b1;
            end else if (w_commit) begin
                r_pend_flag <= 1'b0;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;
    assign o_pending = r_pend_flag;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock-enable generator.
// Define CLKDIV_CASCADE_EN to chain each channel onto the tick of the one below it.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int CH          = 3,
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int DEFAULT_DIV = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    en,
    input  logic [CH-1:0]    div_wr,
    input  logic [DIV_W-1:0] div_wdata,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    div_pending
);

    logic [CH-1:0] w_advance;

`ifdef CLKDIV_CASCADE_EN
    assign w_advance[0] = en[0];
    generate
        if (CH > 1) begin : g_cascade
            assign w_advance[CH-1:1] = en[CH-1:1] & tick[CH-2:0];
        end
    endgenerate
`else
    assign w_advance = en;
`endif

    generate
        for (genvar g = 0; g < CH; g++) begin : g_ch
            clkdiv_channel #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DIV_W'(DEFAULT_DIV))
            ) u_channel (
                .clk       (clk),
                .reset     (reset),
                .i_advance (w_advance[g]),
                .i_wr      (div_wr[g]),
                .i_wdata   (div_wdata),
                .o_tick    (tick[g]),
                .o_clk_out (clk_out[g]),
                .o_pending (div_pending[g])
            );
        end
    endgenerate

endmodule
